// File: rtl/heart_ctrl.sv
// ---------------------------------------------------------------------------
// heart_ctrl
// Player-heart controller for the fight screen. UART key bytes become
// per-axis movement intents that stay active for HOLD_FRAMES animation
// strobes, the heart moves once per strobe clamped to a run-time fighting
// box, and accepted keys are echoed back over UART through a one-deep
// busy-aware buffer.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_ani_stb, i_animate   frame strobe and movement enable
//   i_rx_receive/i_rx_data received UART byte (one-cycle valid pulse)
//   i_box_x0..i_box_y1     inclusive fighting-box edges
//   i_tx_busy              UART TX not ready
//   o_cx, o_cy, o_r        heart centre and constant radius
//   o_slow, o_wall         slow mode, last move was clamped
//   o_tx_transmit/o_tx_data one-cycle echo pulse and its byte
// ---------------------------------------------------------------------------
module heart_ctrl #(
    parameter int         COORD_W     = 16,
    parameter int         R           = 5,
    parameter int         VELOCITY    = 5,
    parameter int         HOLD_FRAMES = 4,
    parameter int         START_X     = 250,
    parameter int         START_Y     = 235,
    parameter logic [7:0] KEY_UP      = 8'h77,
    parameter logic [7:0] KEY_LEFT    = 8'h61,
    parameter logic [7:0] KEY_DOWN    = 8'h73,
    parameter logic [7:0] KEY_RIGHT   = 8'h64,
    parameter logic [7:0] KEY_SLOW    = 8'h6B
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_animate,
    input  logic               i_rx_receive,
    input  logic [7:0]         i_rx_data,
    input  logic [COORD_W-1:0] i_box_x0,
    input  logic [COORD_W-1:0] i_box_y0,
    input  logic [COORD_W-1:0] i_box_x1,
    input  logic [COORD_W-1:0] i_box_y1,
    input  logic               i_tx_busy,
    output logic [COORD_W-1:0] o_cx,
    output logic [COORD_W-1:0] o_cy,
    output logic [COORD_W-1:0] o_r,
    output logic               o_slow,
    output logic               o_wall,
    output logic               o_tx_transmit,
    output logic [7:0]         o_tx_data
);

    // Two guard bits let targets go below zero or past the coordinate range
    // without wrapping, so those cases clamp like any other bound.
    localparam int W2 = COORD_W + 2;
    localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic [HW-1:0]        C_HOLD      = HW'(HOLD_FRAMES);
    localparam logic signed [W2-1:0] C_R         = W2'(R);
    localparam logic signed [W2-1:0] C_STEP_FAST = W2'(VELOCITY);
    localparam logic signed [W2-1:0] C_STEP_SLOW =
        W2'(((VELOCITY >> 1) < 1) ? 1 : (VELOCITY >> 1));
    localparam logic signed [W2-1:0] C_MAX       = {2'b00, {COORD_W{1'b1}}};

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    logic [1:0]         r_dx;
    logic [1:0]         r_dy;
    logic [HW-1:0]      r_hx;
    logic [HW-1:0]      r_hy;
    logic               r_slow;
    logic               r_wall;
    logic [0:0]         r_state;
    logic [7:0]         r_store;
    logic               r_tx_transmit;
    logic [7:0]         r_tx_data;

    logic w_key_up;
    logic w_key_left;
    logic w_key_down;
    logic w_key_right;
    logic w_key_slow;
    logic w_accept;
    logic w_strobe;
    logic w_tx_free;

    logic signed [W2-1:0] w_step;
    logic signed [W2-1:0] w_x_tgt;
    logic signed [W2-1:0] w_y_tgt;
    logic signed [W2-1:0] w_x_lo;
    logic signed [W2-1:0] w_x_hi;
    logic signed [W2-1:0] w_y_lo;
    logic signed [W2-1:0] w_y_hi;
    logic signed [W2-1:0] w_x_new;
    logic signed [W2-1:0] w_y_new;

    // Position plus the signed step, but only while the hold counter runs.
    function automatic logic signed [W2-1:0] move_target(
        input logic [COORD_W-1:0]   pos,
        input logic [1:0]           dir,
        input logic [HW-1:0]        hcnt,
        input logic signed [W2-1:0] step
    );
        logic signed [W2-1:0] p;
        p = $signed({2'b00, pos});
        if (hcnt != '0 && dir == DIR_POS) begin
            return p + step;
        end else if (hcnt != '0 && dir == DIR_NEG) begin
            return p - step;
        end
        return p;
    endfunction

    // Box clamp first (an inverted box pins to lo), then the coordinate range.
    function automatic logic signed [W2-1:0] clamp_axis(
        input logic signed [W2-1:0] tgt,
        input logic signed [W2-1:0] lo,
        input logic signed [W2-1:0] hi
    );
        logic signed [W2-1:0] v;
        if (hi < lo) begin
            v = lo;
        end else if (tgt < lo) begin
            v = lo;
        end else if (tgt > hi) begin
            v = hi;
        end else begin
            v = tgt;
        end
        if (v < 0) begin
            v = '0;
        end else if (v > C_MAX) begin
            v = C_MAX;
        end
        return v;
    endfunction

    assign w_key_up    = i_rx_receive && (i_rx_data == KEY_UP);
    assign w_key_left  = i_rx_receive && (i_rx_data == KEY_LEFT);
    assign w_key_down  = i_rx_receive && (i_rx_data == KEY_DOWN);
    assign w_key_right = i_rx_receive && (i_rx_data == KEY_RIGHT);
    assign w_key_slow  = i_rx_receive && (i_rx_data == KEY_SLOW);
    assign w_accept    = w_key_up | w_key_left | w_key_down | w_key_right | w_key_slow;
    assign w_strobe    = i_ani_stb && i_animate;

    // The strobe always sees the registered (pre-byte) slow and axis state.
    assign w_step  = r_slow ? C_STEP_SLOW : C_STEP_FAST;
    assign w_x_tgt = move_target(r_cx, r_dx, r_hx, w_step);
    assign w_y_tgt = move_target(r_cy, r_dy, r_hy, w_step);
    assign w_x_lo  = $signed({2'b00, i_box_x0}) + C_R;
    assign w_x_hi  = $signed({2'b00, i_box_x1}) - C_R;
    assign w_y_lo  = $signed({2'b00, i_box_y0}) + C_R;
    assign w_y_hi  = $signed({2'b00, i_box_y1}) - C_R;
    assign w_x_new = clamp_axis(w_x_tgt, w_x_lo, w_x_hi);
    assign w_y_new = clamp_axis(w_y_tgt, w_y_lo, w_y_hi);

    // A pulse in the previous cycle counts as busy so pulses never touch.
    assign w_tx_free = !i_tx_busy && !r_tx_transmit;

    // Movement: position and wall flag change only on qualifying strobes;
    // a key load on an axis takes priority over that axis's decrement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cx   <= COORD_W'(START_X);
            r_cy   <= COORD_W'(START_Y);
            r_dx   <= DIR_NONE;
            r_dy   <= DIR_NONE;
            r_hx   <= '0;
            r_hy   <= '0;
            r_slow <= 1'b0;
            r_wall <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_cx   <= w_x_new[COORD_W-1:0];
                r_cy   <= w_y_new[COORD_W-1:0];
                r_wall <= (w_x_tgt != w_x_new) || (w_y_tgt != w_y_new);
            end

            if (w_key_right) begin
                r_dx <= DIR_POS;
                r_hx <= C_HOLD;
            end else if (w_key_left) begin
                r_dx <= DIR_NEG;
                r_hx <= C_HOLD;
            end else if (w_strobe && r_hx != '0) begin
                r_hx <= r_hx - HW'(1);
            end

            if (w_key_down) begin
                r_dy <= DIR_POS;
                r_hy <= C_HOLD;
            end else if (w_key_up) begin
                r_dy <= DIR_NEG;
                r_hy <= C_HOLD;
            end else if (w_strobe && r_hy != '0) begin
                r_hy <= r_hy - HW'(1);
            end

            if (w_key_slow) begin
                r_slow <= ~r_slow;
            end
        end
    end

    // Echo buffer: a newer accepted byte always replaces the stored one, and
    // in PEND a byte arriving on the send cycle is the one that goes out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_store       <= '0;
            r_tx_transmit <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_tx_transmit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_tx_free) begin
                            r_tx_transmit <= 1'b1;
                            r_tx_data     <= i_rx_data;
                        end else begin
                            r_store <= i_rx_data;
                            r_state <= S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (w_tx_free) begin
                        r_tx_transmit <= 1'b1;
                        r_tx_data     <= w_accept ? i_rx_data : r_store;
                        r_state       <= S_IDLE;
                    end else if (w_accept) begin
                        r_store <= i_rx_data;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cx          = r_cx;
    assign o_cy          = r_cy;
    assign o_r           = COORD_W'(R);
    assign o_slow        = r_slow;
    assign o_wall        = r_wall;
    assign o_tx_transmit = r_tx_transmit;
    assign o_tx_data     = r_tx_data;

endmodule

// File: tb/tb_heart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_heart_ctrl
// Self-checking bench for heart_ctrl: directed scenarios with hand-computed
// expectations, then randomized keys/strobes/busy/boxes compared every cycle
// against a behavioural model of the heart position, hold timers and echo.
// ---------------------------------------------------------------------------
module tb_heart_ctrl;

    localparam int CW   = 16;
    localparam int R    = 5;
    localparam int V    = 5;
    localparam int HOLD = 4;
    localparam int SX   = 250;
    localparam int SY   = 235;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ani_stb;
    logic          i_animate;
    logic          i_rx_receive;
    logic [7:0]    i_rx_data;
    logic [CW-1:0] i_box_x0;
    logic [CW-1:0] i_box_y0;
    logic [CW-1:0] i_box_x1;
    logic [CW-1:0] i_box_y1;
    logic          i_tx_busy;
    logic [CW-1:0] o_cx;
    logic [CW-1:0] o_cy;
    logic [CW-1:0] o_r;
    logic          o_slow;
    logic          o_wall;
    logic          o_tx_transmit;
    logic [7:0]    o_tx_data;

    int nChecks = 0;
    int nFails  = 0;
    bit checkEn = 0;
    int txSeen  = 0;
    logic [7:0] lastTx = 8'h00;

    // Behavioural model state: plain integers per axis plus an echo slot.
    longint mPos [2];
    longint mHold[2];
    longint mDir [2];
    bit     mSlow;
    bit     mWall;
    bit     mTx;
    logic [7:0] mTxData;
    bit     mPend;
    logic [7:0] mPendByte;

    always #5 clk = ~clk;

    heart_ctrl #(
        .COORD_W(CW), .R(R), .VELOCITY(V), .HOLD_FRAMES(HOLD),
        .START_X(SX), .START_Y(SY),
        .KEY_UP(8'h77), .KEY_LEFT(8'h61), .KEY_DOWN(8'h73),
        .KEY_RIGHT(8'h64), .KEY_SLOW(8'h6B)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ani_stb(i_ani_stb), .i_animate(i_animate),
        .i_rx_receive(i_rx_receive), .i_rx_data(i_rx_data),
        .i_box_x0(i_box_x0), .i_box_y0(i_box_y0),
        .i_box_x1(i_box_x1), .i_box_y1(i_box_y1),
        .i_tx_busy(i_tx_busy),
        .o_cx(o_cx), .o_cy(o_cy), .o_r(o_r), .o_slow(o_slow), .o_wall(o_wall),
        .o_tx_transmit(o_tx_transmit), .o_tx_data(o_tx_data)
    );

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; inputs change just after the rising edge.
    task automatic applyStimulus(input bit rx, input logic [7:0] d, input bit stb);
        i_rx_receive = rx;
        i_rx_data    = d;
        i_ani_stb    = stb;
        @(posedge clk);
        #1;
        i_rx_receive = 1'b0;
        i_ani_stb    = 1'b0;
    endtask

    task automatic sendKey(input logic [7:0] k);
        applyStimulus(1'b1, k, 1'b0);
    endtask

    task automatic strobe();
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic setBox(input int x0, input int y0, input int x1, input int y1);
        i_box_x0 = CW'(x0);
        i_box_y0 = CW'(y0);
        i_box_x1 = CW'(x1);
        i_box_y1 = CW'(y1);
    endtask

    // Reference model: rules applied to integers at each rising edge.
    always @(posedge clk) begin : model
        longint step, tgt, lo, hi, res;
        bit wallNow, free, newTx;
        if (rst) begin
            mPos[0] = SX;  mPos[1] = SY;
            mHold[0] = 0;  mHold[1] = 0;
            mDir[0] = 0;   mDir[1] = 0;
            mSlow = 0; mWall = 0; mTx = 0; mTxData = 8'h00;
            mPend = 0; mPendByte = 8'h00;
        end else begin
            if (i_ani_stb && i_animate) begin
                step = mSlow ? (((V >> 1) < 1) ? 1 : (V >> 1)) : V;
                wallNow = 0;
                for (int a = 0; a < 2; a++) begin
                    tgt = mPos[a] + ((mHold[a] > 0) ? mDir[a] * step : 0);
                    lo  = ((a == 0) ? longint'(i_box_x0) : longint'(i_box_y0)) + R;
                    hi  = ((a == 0) ? longint'(i_box_x1) : longint'(i_box_y1)) - R;
                    if (hi < lo)       res = lo;
                    else if (tgt < lo) res = lo;
                    else if (tgt > hi) res = hi;
                    else               res = tgt;
                    if (res < 0)    res = 0;
                    if (res > CMAX) res = CMAX;
                    if (res != tgt) wallNow = 1;
                    mPos[a] = res;
                    if (mHold[a] > 0) mHold[a] = mHold[a] - 1;
                end
                mWall = wallNow;
            end
            if (i_rx_receive) begin
                case (i_rx_data)
                    8'h64: begin mDir[0] =  1; mHold[0] = HOLD; end
                    8'h61: begin mDir[0] = -1; mHold[0] = HOLD; end
                    8'h73: begin mDir[1] =  1; mHold[1] = HOLD; end
                    8'h77: begin mDir[1] = -1; mHold[1] = HOLD; end
                    8'h6B: mSlow = !mSlow;
                    default: ;
                endcase
                if (i_rx_data inside {8'h64, 8'h61, 8'h73, 8'h77, 8'h6B}) begin
                    mPend = 1;
                    mPendByte = i_rx_data;
                end
            end
            free  = !i_tx_busy && !mTx;
            newTx = 0;
            if (mPend && free) begin
                newTx   = 1;
                mTxData = mPendByte;
                mPend   = 0;
            end
            mTx = newTx;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cx",   64'(o_cx),   64'(mPos[0]));
            checkOutput("cy",   64'(o_cy),   64'(mPos[1]));
            checkOutput("r",    64'(o_r),    64'(R));
            checkOutput("slow", 64'(o_slow), 64'(mSlow));
            checkOutput("wall", 64'(o_wall), 64'(mWall));
            checkOutput("tx",   64'(o_tx_transmit), 64'(mTx));
            if (mTx) checkOutput("txData", 64'(o_tx_data), 64'(mTxData));
        end
        if (o_tx_transmit === 1'b1) begin
            txSeen++;
            lastTx = o_tx_data;
        end
    end

    initial begin : stim
        logic [7:0] keys[5];
        int base;
        keys = '{8'h77, 8'h61, 8'h73, 8'h64, 8'h6B};
        rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b1; i_rx_receive = 1'b0;
        i_rx_data = 8'h00; i_tx_busy = 1'b0;
        setBox(245, 230, 395, 380);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkEn = 1;

        $display("[TB] reset values");
        checkOutput("rstCx",   64'(o_cx), 64'd250);
        checkOutput("rstCy",   64'(o_cy), 64'd235);
        checkOutput("rstSlow", 64'(o_slow), 64'd0);
        checkOutput("rstWall", 64'(o_wall), 64'd0);
        checkOutput("rstTx",   64'(o_tx_transmit), 64'd0);
        checkOutput("rstTxD",  64'(o_tx_data), 64'd0);

        $display("[TB] single key hold");
        sendKey(8'h64);
        checkOutput("echoNow",  64'(o_tx_transmit), 64'd1);
        checkOutput("echoByte", 64'(o_tx_data), 64'h64);
        strobe(); checkOutput("hold1", 64'(o_cx), 64'd255);
        strobe(); checkOutput("hold2", 64'(o_cx), 64'd260);
        strobe(); checkOutput("hold3", 64'(o_cx), 64'd265);
        strobe(); checkOutput("hold4", 64'(o_cx), 64'd270);
        strobe(); checkOutput("hold5", 64'(o_cx), 64'd270);

        $display("[TB] shrinking box");
        i_box_x1 = CW'(270);
        strobe();
        checkOutput("shrinkCx",   64'(o_cx), 64'd265);
        checkOutput("shrinkWall", 64'(o_wall), 64'd1);
        i_box_x1 = CW'(254);
        strobe();
        checkOutput("invertCx", 64'(o_cx), 64'd250);
        i_box_x1 = CW'(395);

        $display("[TB] right wall");
        for (int i = 0; i < 6; i++) begin
            sendKey(8'h64);
            for (int j = 0; j < 4; j++) strobe();
        end
        sendKey(8'h64);
        for (int j = 0; j < 3; j++) strobe();
        checkOutput("reach385", 64'(o_cx), 64'd385);
        sendKey(8'h64);
        strobe();
        checkOutput("reach390", 64'(o_cx), 64'd390);
        checkOutput("noWall",   64'(o_wall), 64'd0);
        strobe();
        checkOutput("stay390",  64'(o_cx), 64'd390);
        checkOutput("wallHit",  64'(o_wall), 64'd1);

        $display("[TB] diagonal and slow mode");
        sendKey(8'h73);
        sendKey(8'h61);
        strobe();
        checkOutput("diagX", 64'(o_cx), 64'd385);
        checkOutput("diagY", 64'(o_cy), 64'd240);
        sendKey(8'h6B);
        checkOutput("slowOn", 64'(o_slow), 64'd1);
        sendKey(8'h61);
        strobe();
        checkOutput("slowX", 64'(o_cx), 64'd383);
        checkOutput("slowY", 64'(o_cy), 64'd242);
        sendKey(8'h6B);
        checkOutput("slowOff", 64'(o_slow), 64'd0);

        $display("[TB] randomized phase");
        for (int i = 0; i < 2000; i++) begin
            bit rx, stb;
            logic [7:0] d;
            rx  = ($urandom_range(0, 99) < 30);
            d   = ($urandom_range(0, 99) < 80) ? keys[$urandom_range(0, 4)]
                                               : 8'($urandom_range(0, 255));
            stb = ($urandom_range(0, 99) < 30);
            i_animate = ($urandom_range(0, 99) < 85);
            i_tx_busy = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0: setBox(245, 230, 395, 380);
                    1: setBox($urandom_range(0, 400), $urandom_range(0, 400),
                              $urandom_range(0, 700), $urandom_range(0, 700));
                    2: setBox($urandom_range(0, 300), $urandom_range(0, 300),
                              $urandom_range(300, 320), $urandom_range(300, 320));
                    default: setBox($urandom_range(65520, 65535), $urandom_range(0, 10),
                                    65535, $urandom_range(0, 20));
                endcase
            end
            applyStimulus(rx, d, stb);
        end
        i_animate = 1'b1;
        i_tx_busy = 1'b0;
        setBox(245, 230, 395, 380);
        idle(4);

        $display("[TB] busy echo buffer");
        i_tx_busy = 1'b1;
        base = txSeen;
        sendKey(8'h77);
        sendKey(8'h73);
        idle(1);
        i_tx_busy = 1'b0;
        idle(4);
        checkOutput("pendCount", 64'(txSeen - base), 64'd1);
        checkOutput("pendByte",  64'(lastTx), 64'h73);
        base = txSeen;
        sendKey(8'h41);
        idle(3);
        checkOutput("ignoredByte", 64'(txSeen - base), 64'd0);

        $display("[TB] reset mid-operation");
        i_tx_busy = 1'b1;
        sendKey(8'h64);
        sendKey(8'h6B);
        strobe();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midRstCx",   64'(o_cx), 64'd250);
        checkOutput("midRstCy",   64'(o_cy), 64'd235);
        checkOutput("midRstSlow", 64'(o_slow), 64'd0);
        checkOutput("midRstWall", 64'(o_wall), 64'd0);
        checkOutput("midRstTx",   64'(o_tx_transmit), 64'd0);
        checkOutput("midRstTxD",  64'(o_tx_data), 64'd0);
        base = txSeen;
        i_tx_busy = 1'b0;
        idle(5);
        checkOutput("noEchoAfterRst", 64'(txSeen - base), 64'd0);
        strobe();
        checkOutput("holdCleared", 64'(o_cx), 64'd250);

        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
